posit_encoder: RTL and testbench

POSIT_ENCODER -- requirements
Module: posit_encoder

---
 rtl/posit_pkg.sv | 24 ++
 rtl/posit_round.sv | 64 ++++++
 rtl/posit_encoder.sv | 125 ++++++++++++
 tb/tb_posit_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared defaults, special encodings and the operand-class enum used by the
// posit encoder pipeline.
package posit_pkg;

  localparam int DEF_N  = 8;
  localparam int DEF_ES = 1;
  localparam int DEF_RS = 4;
  localparam int DEF_FS = DEF_N - DEF_ES - 3;

  localparam logic [DEF_N-1:0] ZERO   = 8'h00;
  localparam logic [DEF_N-1:0] NAR    = 8'h80;
  localparam logic [DEF_N-1:0] MAXPOS = 8'h7F;
  localparam logic [DEF_N-1:0] MINPOS = 8'h01;

  // Operand class resolved in stage 1 so stage 2 only rounds and signs.
  typedef enum logic [2:0] {
    KIND_NORM = 3'd0,
    KIND_ZERO = 3'd1,
    KIND_NAR  = 3'd2,
    KIND_MAXP = 3'd3,
    KIND_MINP = 3'd4
  } kind_e;

endpackage

// File: rtl/posit_round.sv
// Combinational round-to-nearest-even, magnitude clamp to [MINPOS, MAXPOS],
// sign application and special-value bypass for the posit encoder.
module posit_round
  import posit_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  kind_e        kind,
  input  logic         sign,
  input  logic [N-2:0] body,
  input  logic         guard,
  input  logic         rsticky,
  output logic [N-1:0] posit
);

  localparam logic [N-2:0] MAG_MAX   = {(N-1){1'b1}};
  localparam logic [N-2:0] MAG_MIN   = {{(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0] WORD_NAR  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] WORD_ZERO = {N{1'b0}};

  logic         inc_s;
  logic [N-1:0] sum_s;
  logic [N-2:0] mag_s;
  logic [N-1:0] word_s;

  // Round the body to nearest-even; a carry out or a zero result is clamped
  // so that a nonzero value never becomes zero or NaR.
  always_comb begin
    inc_s = guard & (rsticky | body[0]);
    sum_s = {1'b0, body} + {{(N-1){1'b0}}, inc_s};
    mag_s = MAG_MIN;
    case (kind)
      KIND_MAXP: mag_s = MAG_MAX;
      KIND_MINP: mag_s = MAG_MIN;
      KIND_NORM: begin
        if (sum_s[N-1]) begin
          mag_s = MAG_MAX;
        end else if (sum_s[N-2:0] == {(N-1){1'b0}}) begin
          mag_s = MAG_MIN;
        end else begin
          mag_s = sum_s[N-2:0];
        end
      end
      default: mag_s = MAG_MIN;
    endcase
  end

  // Zero and NaR ignore the sign; everything else is negated as a whole word.
  always_comb begin
    word_s = {1'b0, mag_s};
    case (kind)
      KIND_NAR:  posit = WORD_NAR;
      KIND_ZERO: posit = WORD_ZERO;
      default: begin
        if (sign) begin
          posit = ~word_s + {{(N-1){1'b0}}, 1'b1};
        end else begin
          posit = word_s;
        end
      end
    endcase
  end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage posit encoder: stage 1 lays out regime/exponent/fraction and
// extracts guard and round-sticky, stage 2 rounds, signs and holds the word.
module posit_encoder
  import posit_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int ES = DEF_ES,
  parameter  int RS = DEF_RS,
  localparam int FS = N - ES - 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sign,
  input  logic          zero,
  input  logic          nar,
  input  logic [RS-1:0] regi,
  input  logic [ES-1:0] expo,
  input  logic [FS-1:0] frac,
  input  logic          sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  posit
);

  // Longest in-range regime is N-1 bits, followed by exponent and fraction.
  localparam int TW = N - 1 + ES + FS;

  int            k_s;
  logic [TW-1:0] base_pos_s;
  logic [TW-1:0] base_neg_s;
  logic [TW-1:0] str_s;
  kind_e         kind_s;

  logic          s1_valid_r;
  kind_e         s1_kind_r;
  logic          s1_sign_r;
  logic [N-2:0]  s1_body_r;
  logic          s1_guard_r;
  logic          s1_rsticky_r;

  logic          s2_valid_r;
  logic [N-1:0]  posit_r;
  logic [N-1:0]  rnd_posit_s;

  logic          s1_load_s;
  logic          s2_load_s;

  assign s2_load_s = !s2_valid_r || out_ready;
  assign s1_load_s = !s1_valid_r || s2_load_s;
  assign in_ready  = s1_load_s;
  assign out_valid = s2_valid_r;
  assign posit     = posit_r;

  // Classify the operand and build the MSB-first bit string: the regime
  // terminator plus tail is shifted down, filling with the regime run bit.
  always_comb begin
    k_s        = int'($signed(regi));
    base_pos_s = {1'b0, expo, frac, {(TW-1-ES-FS){1'b0}}};
    base_neg_s = {1'b1, expo, frac, {(TW-1-ES-FS){1'b0}}};
    if (k_s >= 32'sd0) begin
      str_s = ~((~base_pos_s) >> (k_s + 32'sd1));
    end else begin
      str_s = base_neg_s >> (32'sd0 - k_s);
    end
    if (nar) begin
      kind_s = KIND_NAR;
    end else if (zero) begin
      kind_s = KIND_ZERO;
    end else if (k_s >= N - 32'sd2) begin
      kind_s = KIND_MAXP;
    end else if (k_s <= 32'sd1 - N) begin
      kind_s = KIND_MINP;
    end else begin
      kind_s = KIND_NORM;
    end
  end

  // Stage 1 register: unrounded body, guard and round-sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_kind_r    <= KIND_ZERO;
      s1_sign_r    <= 1'b0;
      s1_body_r    <= {(N-1){1'b0}};
      s1_guard_r   <= 1'b0;
      s1_rsticky_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r   <= in_valid;
      s1_kind_r    <= kind_s;
      s1_sign_r    <= sign;
      s1_body_r    <= str_s[TW-1 -: N-1];
      s1_guard_r   <= str_s[TW-N];
      s1_rsticky_r <= (|str_s[TW-N-1:0]) | sticky;
    end else begin
      s1_valid_r   <= s1_valid_r;
    end
  end

  posit_round #(
    .N(N)
  ) u_round (
    .kind    (s1_kind_r),
    .sign    (s1_sign_r),
    .body    (s1_body_r),
    .guard   (s1_guard_r),
    .rsticky (s1_rsticky_r),
    .posit   (rnd_posit_s)
  );

  // Stage 2 register: final word, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      posit_r    <= {N{1'b0}};
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      posit_r    <= rnd_posit_s;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Self-checking bench for posit_encoder: a bit-string reference model feeds a
// scoreboard checked on every valid output, plus directed pins and
// handshake/reset scenarios.
module tb_posit_encoder;

  localparam int N  = 8;
  localparam int ES = 1;
  localparam int RS = 4;
  localparam int FS = N - ES - 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          sign;
  logic          zero;
  logic          nar;
  logic [RS-1:0] regi;
  logic [ES-1:0] expo;
  logic [FS-1:0] frac;
  logic          sticky;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  posit;

  int            checks;
  int            failures;
  logic [N-1:0]  sb_q[$];
  logic          prev_stall;
  logic [N-1:0]  prev_posit;
  logic [N-1:0]  exp_word;

  posit_encoder #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .zero      (zero),
    .nar       (nar),
    .regi      (regi),
    .expo      (expo),
    .frac      (frac),
    .sticky    (sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .posit     (posit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: spell out the posit bit string, cut it at N-1 bits, round.
  function automatic logic [N-1:0] model(input logic s, input logic z, input logic n,
                                         input int k, input int e, input int f,
                                         input logic st);
    bit q[$];
    int body;
    int guard;
    int rs;
    int mag;
    int maxmag;
    logic [N-1:0] r;
    maxmag = (1 << (N - 1)) - 1;
    if (n) return 8'h80;
    if (z) return 8'h00;
    if (k >= N - 2) begin
      mag = maxmag;
    end else if (k <= -(N - 1)) begin
      mag = 1;
    end else begin
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = ES - 1; i >= 0; i--) q.push_back(e[i]);
      for (int i = FS - 1; i >= 0; i--) q.push_back(f[i]);
      while (q.size() < N) q.push_back(1'b0);
      body = 0;
      for (int i = 0; i < N - 1; i++) body = body * 2 + int'(q[i]);
      guard = int'(q[N-1]);
      rs = int'(st);
      for (int i = N; i < q.size(); i++) rs = rs | int'(q[i]);
      if (guard == 1 && (rs == 1 || (body % 2) == 1)) body = body + 1;
      if (body > maxmag) body = maxmag;
      if (body == 0) body = 1;
      mag = body;
    end
    r = s ? N'((1 << N) - mag) : N'(mag);
    return r;
  endfunction

  task automatic send(input logic s, input logic z, input logic n,
                      input int k, input int e, input int f, input logic st);
    bit acc;
    sign = s; zero = z; nar = n;
    regi = RS'(k); expo = ES'(e); frac = FS'(f); sticky = st;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted inputs, check every valid output and hold.
  initial begin
    prev_stall = 1'b0;
    prev_posit = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall) begin
          check("stall_hold_valid", 32'(out_valid), 32'd1);
          check("stall_hold_posit", 32'(posit), 32'(prev_posit));
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", sb_q.size(), 32'd1);
          end else begin
            check("posit_out", 32'(posit), 32'(sb_q[0]));
            if (out_ready) void'(sb_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_posit = posit;
        if (in_valid && in_ready)
          sb_q.push_back(model(sign, zero, nar, int'($signed(regi)), int'(expo), int'(frac), sticky));
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sign = 1'b0; zero = 1'b0; nar = 1'b0; regi = '0; expo = '0; frac = '0; sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_posit", 32'(posit), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Pin the reference model with hand-derived encodings.
    check("model_k0",      32'(model(0, 0, 0,  0, 0,  0, 0)), 32'h40);
    check("model_k0_neg",  32'(model(1, 0, 0,  0, 0,  0, 0)), 32'hC0);
    check("model_k1",      32'(model(0, 0, 0,  1, 1,  8, 0)), 32'h6C);
    check("model_km1",     32'(model(0, 0, 0, -1, 0,  0, 0)), 32'h20);
    check("model_tie",     32'(model(0, 0, 0,  5, 1,  0, 0)), 32'h7E);
    check("model_up",      32'(model(0, 0, 0,  5, 1,  1, 0)), 32'h7F);
    check("model_sticky",  32'(model(0, 0, 0,  5, 1,  0, 1)), 32'h7F);
    check("model_maxpos",  32'(model(0, 0, 0,  6, 0,  0, 0)), 32'h7F);
    check("model_minpos7", 32'(model(0, 0, 0, -7, 0,  0, 0)), 32'h01);
    check("model_minpos6", 32'(model(0, 0, 0, -6, 0,  0, 0)), 32'h01);
    check("model_nar",     32'(model(0, 1, 1,  3, 1,  5, 1)), 32'h80);
    check("model_zero",    32'(model(1, 1, 0,  2, 1,  3, 0)), 32'h00);
    check("model_k2_even", 32'(model(0, 0, 0,  2, 1, 10, 0)), 32'h76);
    check("model_k2_odd",  32'(model(0, 0, 0,  2, 1, 14, 0)), 32'h78);
    check("model_negmax",  32'(model(1, 0, 0,  6, 1, 15, 0)), 32'h81);

    // Directed vectors streamed with the consumer always ready.
    send(0, 0, 0,  0, 0,  0, 0);
    send(1, 0, 0,  0, 0,  0, 0);
    send(0, 0, 0,  1, 1,  8, 0);
    send(0, 0, 0, -1, 0,  0, 0);
    send(0, 0, 0,  5, 1,  0, 0);
    send(0, 0, 0,  5, 1,  1, 0);
    send(0, 0, 0,  5, 1,  0, 1);
    send(0, 0, 0,  6, 0,  0, 0);
    send(0, 0, 0,  7, 1, 15, 1);
    send(0, 0, 0, -7, 0,  0, 0);
    send(0, 0, 0, -6, 0,  0, 0);
    send(0, 0, 0, -8, 1, 15, 1);
    send(0, 1, 1,  3, 1,  5, 1);
    send(1, 1, 0,  2, 1,  3, 0);
    send(1, 0, 0,  6, 1, 15, 0);
    send(0, 0, 0,  2, 1, 10, 0);
    send(0, 0, 0,  2, 1, 14, 0);
    send(1, 0, 0, -3, 1,  9, 1);
    drain();

    // Stall: two accepts fill both stages, then input backpressure.
    out_ready = 1'b0;
    send(0, 0, 0,  1, 1,  8, 0);
    send(1, 0, 0, -2, 0,  5, 0);
    @(negedge clk);
    check("stall_in_ready_low", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(0, 0, 0,  3, 0,  7, 1);
    drain();

    // Accept and drain in the same cycles with an irregular ready pattern.
    fork
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk);
          #1;
          out_ready = ((c % 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int v = 0; v < 10; v++)
          send(logic'(v % 2), 0, 0, (v % 12) - 6, v % 2, (v * 5) % 16, logic'(v % 3 == 0));
      end
    join
    drain();

    // Reset with both stages full discards everything immediately.
    out_ready = 1'b0;
    send(0, 0, 0, 0, 1, 2, 0);
    send(0, 0, 0, 1, 0, 3, 0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_posit", 32'(posit), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_word = model(0, 0, 0, 1, 1, 8, 0);
    sign = 1'b0; zero = 1'b0; nar = 1'b0; regi = 4'd1; expo = 1'b1; frac = 4'd8; sticky = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("latency_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_cycle2_valid", 32'(out_valid), 32'd1);
    check("latency_cycle2_posit", 32'(posit), 32'(exp_word));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
